// File: rtl/aznable_ioctl_pkg.sv
// Shared ioctl definitions used by the download decode and the upload responder.
package aznable_ioctl_pkg;

  // Upload responder state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;
  localparam logic [1:0] ST_FETCH = 2'd3;

  // Byte returned to the HPS for any address outside the saved region
  localparam logic [7:0] FILL_BYTE = 8'hFF;

  // ioctl index assignments
  localparam logic [7:0] IDX_BIOS   = 8'd0;
  localparam logic [7:0] IDX_SPRITE = 8'd3;
  localparam logic [7:0] IDX_MUSIC  = 8'd4;
  localparam logic [7:0] IDX_UPLOAD = 8'd5;

  // Unsigned range test of a full 25-bit HPS address against a zero-extended length.
  // Any set bit above the memory width makes the address larger than any legal length.
  function automatic logic addr_in_range(input logic [24:0] addr, input logic [24:0] len);
    return (addr < len);
  endfunction

endpackage

// File: rtl/ioctl_uploader.sv
// Core-to-HPS upload responder: requests an upload from hps_io on a save request,
// then answers each HPS byte read by fetching from a fixed-latency memory port.
module ioctl_uploader
  import aznable_ioctl_pkg::*;
#(
  parameter int         ADDR_W       = 16,
  parameter int         MEM_LATENCY  = 2,
  parameter logic [7:0] UPLOAD_INDEX = IDX_UPLOAD,
  parameter int         TO_W         = 24
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              save_req,
  input  logic [ADDR_W:0]   save_len,
  output logic              ioctl_upload_req,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_dout,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  localparam logic [2:0] LAT_LOAD = 3'(MEM_LATENCY);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [2:0]        lat_q, lat_d;
  logic              upload_prev_q;
  logic              req_q, req_d;
  logic [7:0]        din_q, din_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;

  logic              upload_fall;
  logic              rd_in_range;

  assign upload_fall = upload_prev_q & ~ioctl_upload;
  assign rd_in_range = addr_in_range(ioctl_addr, 25'(len_q));

  // Next-state logic: FSM, request timeout and memory latency countdown
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    to_cnt_d   = to_cnt_q;
    lat_d      = lat_q;
    req_d      = req_q;
    din_d      = din_q;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    done_d     = 1'b0;
    timeout_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (save_req && (save_len != {(ADDR_W+1){1'b0}})) begin
          len_d    = save_len;
          to_cnt_d = {TO_W{1'b0}};
          req_d    = 1'b1;
          state_d  = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REQ: begin
        if (ioctl_upload && (ioctl_index == UPLOAD_INDEX)) begin
          req_d    = 1'b0;
          to_cnt_d = {TO_W{1'b0}};
          state_d  = ST_XFER;
        end else if (&to_cnt_q) begin
          // HPS never picked up the request
          req_d     = 1'b0;
          to_cnt_d  = {TO_W{1'b0}};
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      ST_XFER, ST_FETCH: begin
        if (upload_fall) begin
          // End of upload wins over everything, an in-flight fetch is dropped
          done_d  = 1'b1;
          lat_d   = 3'd0;
          state_d = ST_IDLE;
        end else if (ioctl_rd) begin
          // The latest strobe always wins, even in the middle of a fetch
          if (rd_in_range) begin
            mem_addr_d = ioctl_addr[ADDR_W-1:0];
            mem_rd_d   = 1'b1;
            lat_d      = LAT_LOAD;
            state_d    = ST_FETCH;
          end else begin
            din_d   = FILL_BYTE;
            lat_d   = 3'd0;
            state_d = ST_XFER;
          end
        end else if (state_q == ST_FETCH) begin
          if (lat_q == 3'd0) begin
            din_d   = mem_dout;
            state_d = ST_XFER;
          end else begin
            lat_d = lat_q - 3'd1;
          end
        end else begin
          state_d = ST_XFER;
        end
      end

      default: begin
        req_d   = 1'b0;
        lat_d   = 3'd0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs, asynchronously forced to idle values
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      len_q         <= {(ADDR_W+1){1'b0}};
      to_cnt_q      <= {TO_W{1'b0}};
      lat_q         <= 3'd0;
      upload_prev_q <= 1'b0;
      req_q         <= 1'b0;
      din_q         <= FILL_BYTE;
      mem_rd_q      <= 1'b0;
      mem_addr_q    <= {ADDR_W{1'b0}};
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      to_cnt_q      <= to_cnt_d;
      lat_q         <= lat_d;
      upload_prev_q <= ioctl_upload;
      req_q         <= req_d;
      din_q         <= din_d;
      mem_rd_q      <= mem_rd_d;
      mem_addr_q    <= mem_addr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
    end
  end

  assign ioctl_upload_req = req_q;
  assign ioctl_din        = din_q;
  assign mem_rd           = mem_rd_q;
  assign mem_addr         = mem_addr_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign timeout          = timeout_q;

endmodule

// File: doc/ioctl_uploader.md
# ioctl_uploader

Core-to-HPS upload responder: the read-side counterpart of the existing ioctl download path into the system. On a save request from the system, it raises `ioctl_upload_req` to hps_io. It then serves each HPS byte read strobe (`ioctl_rd`/`ioctl_addr`) by fetching from a fixed-latency system memory port and presenting the byte on `ioctl_din`. It sits beside hps_io in the emu top and is used for NVRAM and high-score saves.

## Interface
Parameters:
- `ADDR_W`, 16, system memory byte-address width; upload length ≤ 2^ADDR_W.
- `MEM_LATENCY`, 2, cycles from `mem_rd` to valid `mem_dout` (1..7).
- `UPLOAD_INDEX`, 8'd5, ioctl index this block answers to.
- `TO_W`, 24, request-timeout counter width.

Ports:
- `clk_sys` in 1: system clock; all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `save_req` in 1: one-cycle request from system; sampled only in IDLE.
- `save_len` in ADDR_W+1: byte count to upload; latched with `save_req`; 0 is treated as no-op.
- `ioctl_upload_req` out 1: upload request to hps_io.
- `ioctl_upload` in 1: HPS upload in progress.
- `ioctl_index` in 8: current ioctl index.
- `ioctl_rd` in 1: one-cycle byte read strobe.
- `ioctl_addr` in 25: byte address qualifying `ioctl_rd`.
- `ioctl_din` out 8: byte returned to HPS.
- `mem_rd` out 1: one-cycle memory read strobe.
- `mem_addr` out ADDR_W: memory byte address.
- `mem_dout` in 8: memory read data.
- `busy` out 1: high in any state other than IDLE; the system blocks CPU writes to the region while high.
- `done` out 1: one-cycle pulse, upload completed.
- `timeout` out 1: one-cycle pulse, HPS never started.

## Operation
- Reset values for all outputs: `ioctl_upload_req`=0, `ioctl_din`=8'hFF, `mem_rd`=0, `mem_addr`=0, `busy`=0, `done`=0, `timeout`=0. State is IDLE. The latched length, timeout counter and latency counter are 0.
- **IDLE**
  - On `save_req` with `save_len`≠0: latch the length and go to REQ.
  - `save_req` with length 0 is ignored.
  - `save_req` in any other state is ignored; it is not queued.
- **REQ**
  - `ioctl_upload_req`=1 and the timeout counter increments.
  - When `ioctl_upload`=1 and `ioctl_index`==UPLOAD_INDEX: go to XFER, drop the request, clear the counter.
  - If the counter reaches all-ones: pulse `timeout` and go to IDLE.
  - `ioctl_upload` with any other index is ignored.
- **XFER**
  - On `ioctl_rd` with `ioctl_addr` < latched length: drive `mem_addr`=`ioctl_addr[ADDR_W-1:0]`, pulse `mem_rd`, load the latency counter with MEM_LATENCY, go to FETCH.
  - On `ioctl_rd` with `ioctl_addr` ≥ length, including any nonzero bits above ADDR_W: `ioctl_din`=8'hFF on the next cycle and remain in XFER.
  - On `ioctl_upload` falling: pulse `done` and go to IDLE.
- **FETCH**
  - The counter decrements each cycle.
  - At 0, capture `mem_dout` into `ioctl_din` and return to XFER.
  - A new `ioctl_rd` during FETCH aborts the fetch and restarts with the new address: fresh `mem_rd`, counter reloaded. The latest strobe always wins.
  - `ioctl_upload` falling during FETCH: abandon the fetch, pulse `done`, go to IDLE; `ioctl_din` is left unchanged.
- `ioctl_din` holds its last value between reads.
- Length comparison is unsigned at ADDR_W+1 bits, so a full 2^ADDR_W upload is legal.

## Timing
- `ioctl_upload_req` rises the cycle after `save_req`.
- `ioctl_upload_req` falls the cycle after the qualifying `ioctl_upload`.
- In-range read: `mem_rd` registered 1 cycle after `ioctl_rd`; `ioctl_din` valid MEM_LATENCY+1 cycles after `mem_rd`, i.e. MEM_LATENCY+2 cycles after `ioctl_rd`. hps_io spaces strobes ≥16 cycles apart, so this always completes first.
- Out-of-range read: `ioctl_din`=FF 1 cycle after `ioctl_rd`.
- `done` is asserted 1 cycle after the `ioctl_upload` fall.
- `timeout` is asserted on the cycle the counter wraps: 2^TO_W cycles after entering REQ.
- Reset assertion mid-transfer forces reset values immediately, without waiting for a clock edge. Reset deassertion takes effect at the next `clk_sys` edge.

## Structure
- Shared package `aznable_ioctl_pkg`: state enum (IDLE, REQ, XFER, FETCH), the FF fill constant, and ioctl index constants (BIOS 0, sprite 3, music 4, upload 5), also used by download decode.
- A single module; the FSM, timeout counter and latency counter fit inline. No sub-module.

## Test plan
- Nominal upload: `save_len`=4, mem[0..3]=11,22,33,44; HPS starts index 5 and reads addresses 0..3 spaced 20 cycles apart. `mem_rd` appears 1 cycle after each `ioctl_rd`; `ioctl_din`=11,22,33,44 each MEM_LATENCY+2 cycles after its strobe; `done` pulses once after `ioctl_upload` falls.
- Out of range: `save_len`=4, read address 4, then address 0x1_0000 → `ioctl_din`=FF 1 cycle later; no `mem_rd`.
- Wrong index / timeout: `TO_W`=4; HPS asserts `ioctl_upload` with index 3 → `ioctl_upload_req` stays high; `timeout` pulses 16 cycles after entering REQ; `busy`=0 afterwards.
- Overlapping strobes: a second `ioctl_rd` (address 2) arrives 1 cycle into FETCH of address 1 → only mem[2] reaches `ioctl_din`; two `mem_rd` pulses observed.
- Ignored requests: `save_req` during XFER and `save_len`=0 in IDLE → no state change, no `ioctl_upload_req`.
- Reset mid-FETCH: assert `reset_n`=0 → all outputs take reset values before the next edge; a later `save_req` behaves as in the nominal case.
